// File: rtl/proj3_pkg.sv
// Shared types, branch mask and peer-FSM behaviour functions for the Proj_3 sequence driver.
// The same functions serve the RTL shadow and any verification model of the peer.
package proj3_pkg;

    typedef logic [2:0] proj3_state_t;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_SEND = 1'b1
    } ctrl_state_t;

    // Bit i set means the peer consumes the value of a in state i.
    localparam logic [7:0] BRANCH_MASK = 8'b0110_0111;

    function automatic proj3_state_t proj3_next(input proj3_state_t s, input logic a);
        proj3_state_t nxt;
        case (s)
            3'd0:    nxt = a ? 3'd1 : 3'd4;
            3'd1:    nxt = a ? 3'd2 : 3'd3;
            3'd2:    nxt = a ? 3'd3 : 3'd2;
            3'd3:    nxt = 3'd4;
            3'd4:    nxt = 3'd5;
            3'd5:    nxt = a ? 3'd6 : 3'd7;
            3'd6:    nxt = a ? 3'd7 : 3'd6;
            default: nxt = 3'd0;
        endcase
        return nxt;
    endfunction

    function automatic logic proj3_m(input proj3_state_t s, input logic a);
        return (s == 3'd7) | (((s == 3'd2) | (s == 3'd6)) & ~a);
    endfunction

    function automatic logic proj3_n(input proj3_state_t s);
        return (s == 3'd3) | (s == 3'd4);
    endfunction

    function automatic logic proj3_is_branch(input proj3_state_t s);
        return BRANCH_MASK[s];
    endfunction

endpackage

// File: rtl/proj3_shadow.sv
// Cycle-accurate copy of the peer Proj_3 FSM, driven by the same a the peer sees,
// producing the peer's expected m/n outputs.
module proj3_shadow
    import proj3_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a,
    output proj3_state_t state,
    output logic         m_exp,
    output logic         n_exp
);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= 3'd0;
        else        state <= proj3_next(state, a);
    end

    assign m_exp = proj3_m(state, a);
    assign n_exp = proj3_n(state);

endmodule

// File: rtl/proj3_seq_driver.sv
// Bit-serial driver for the peer's a input; spends decision bits only in branching peer states.
// Optional PROJ3_DRV_CHECK_EN adds m_in/n_in inputs and a sticky mismatch flag.
//
// state     | meaning
// CTRL_IDLE | in_ready high, a held 0, waiting for a decision word
// CTRL_SEND | shifting decision bits out whenever the shadow peer branches
module proj3_seq_driver
    import proj3_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LEN_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              a,
    output logic              busy,
    output logic              word_done,
    output logic [2:0]        shadow_state,
    output logic              m_exp,
    output logic              n_exp
`ifdef PROJ3_DRV_CHECK_EN
    ,
    input  logic              m_in,
    input  logic              n_in,
    output logic              mismatch
`endif
);

    ctrl_state_t       ctrl_q, ctrl_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  load_len;
    logic              branch;

    assign load_len = (in_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : in_len;
    assign branch   = proj3_is_branch(shadow_state);

    // a comes only from registered state so the peer never sees a path from in_*.
    assign a         = (ctrl_q == CTRL_SEND) & branch & shreg_q[0];
    assign in_ready  = (ctrl_q == CTRL_IDLE);
    assign busy      = (ctrl_q == CTRL_SEND);
    assign word_done = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        shreg_d = shreg_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (in_valid) begin
                    if (in_len != '0) begin
                        shreg_d = in_data;
                        count_d = load_len;
                        ctrl_d  = CTRL_SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            CTRL_SEND: begin
                if (branch) begin
                    shreg_d = shreg_q >> 1;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        ctrl_d = CTRL_IDLE;
                        done_d = 1'b1;
                    end
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    proj3_shadow u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .state (shadow_state),
        .m_exp (m_exp),
        .n_exp (n_exp)
    );

`ifdef PROJ3_DRV_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                  mismatch <= 1'b0;
        else if ({m_in, n_in} != {m_exp, n_exp})     mismatch <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_proj3_seq_driver.sv
// Directed scoreboard bench for proj3_seq_driver: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_proj3_seq_driver;

    localparam int WORD_W = 8;
    localparam int LEN_W  = $clog2(WORD_W + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [LEN_W-1:0]  in_len;
    logic              a;
    logic              busy;
    logic              word_done;
    logic [2:0]        shadow_state;
    logic              m_exp;
    logic              n_exp;
`ifdef PROJ3_DRV_CHECK_EN
    logic              m_in;
    logic              n_in;
    logic              mismatch;
    logic              inject = 1'b0;
    assign m_in = m_exp ^ inject;
    assign n_in = n_exp;
`endif

    proj3_seq_driver #(.WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_len       (in_len),
        .a            (a),
        .busy         (busy),
        .word_done    (word_done),
        .shadow_state (shadow_state),
        .m_exp        (m_exp),
        .n_exp        (n_exp)
`ifdef PROJ3_DRV_CHECK_EN
        ,
        .m_in         (m_in),
        .n_in         (n_in),
        .mismatch     (mismatch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] vec;  // {state, a, m, n, busy, word_done, in_ready}
        logic       mm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [2:0] s, input logic av, input logic m,
                        input logic n, input logic b, input logic wd, input logic rdy,
                        input logic mm = 1'b0);
        exp_t e;
        e.tag = tag;
        e.vec = {s, av, m, n, b, wd, rdy};
        e.mm  = mm;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {shadow_state, a, m_exp, n_exp, busy, word_done, in_ready};
            checks++;
            if (act !== e.vec) begin
                failures++;
                $display("FAIL %s: got {s,a,m,n,busy,done,rdy}=%b_%b%b%b%b%b%b want %b_%b%b%b%b%b%b",
                         e.tag, act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
                         e.vec[8:6], e.vec[5], e.vec[4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
            end
`ifdef PROJ3_DRV_CHECK_EN
            checks++;
            if (mismatch !== e.mm) begin
                failures++;
                $display("FAIL %s_mismatch: got %b want %b", e.tag, mismatch, e.mm);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        step(2);
        rst_n = 1'b1;

        // idle free-run from reset
        push("idle0", 3'd0, 0, 0, 0, 0, 0, 1);
        push("idle1", 3'd4, 0, 0, 1, 0, 0, 1);
        push("idle2", 3'd5, 0, 0, 0, 0, 0, 1);
        push("idle3", 3'd7, 0, 1, 0, 0, 0, 1);
        push("idle4", 3'd0, 0, 0, 0, 0, 0, 1);
        push("idle5", 3'd4, 0, 0, 1, 0, 0, 1);
        step(6);
        step(2);

        // two-bit word accepted at shadow 0
        in_valid = 1'b1; in_data = 8'h03; in_len = 4'd2;
        push("two0", 3'd0, 0, 0, 0, 0, 0, 1);
        step(1);
        in_valid = 1'b0;
        push("two1", 3'd4, 0, 0, 1, 1, 0, 0);
        push("two2", 3'd5, 1, 0, 0, 1, 0, 0);
        push("two3", 3'd6, 1, 0, 0, 1, 0, 0);
        push("two4", 3'd7, 0, 1, 0, 0, 1, 1);
        push("two5", 3'd0, 0, 0, 0, 0, 0, 1);
        step(5);
        step(2);

        // self-loop word accepted at shadow 7
        in_valid = 1'b1; in_data = 8'h13; in_len = 4'd5;
        push("loop0", 3'd7, 0, 1, 0, 0, 0, 1);
        step(1);
        in_valid = 1'b0;
        push("loop1", 3'd0, 1, 0, 0, 1, 0, 0);
        push("loop2", 3'd1, 1, 0, 0, 1, 0, 0);
        push("loop3", 3'd2, 0, 1, 0, 1, 0, 0);
        push("loop4", 3'd2, 0, 1, 0, 1, 0, 0);
        push("loop5", 3'd2, 1, 0, 0, 1, 0, 0);
        push("loop6", 3'd3, 0, 0, 1, 0, 1, 1);
        push("loop7", 3'd4, 0, 0, 1, 0, 0, 1);
        step(7);

        // back-to-back len-1 words, then a len-0 word
        in_valid = 1'b1; in_data = 8'h01; in_len = 4'd1;
        push("b2b0", 3'd5, 0, 0, 0, 0, 0, 1);
        push("b2b1", 3'd7, 0, 1, 0, 1, 0, 0);
        push("b2b2", 3'd0, 1, 0, 0, 1, 0, 0);
        push("b2b3", 3'd1, 0, 0, 0, 0, 1, 1);
        push("b2b4", 3'd3, 0, 0, 1, 1, 0, 0);
        push("b2b5", 3'd4, 0, 0, 1, 1, 0, 0);
        push("b2b6", 3'd5, 1, 0, 0, 1, 0, 0);
        push("b2b7", 3'd6, 0, 1, 0, 0, 1, 1);
        push("len0", 3'd6, 0, 1, 0, 0, 1, 1);
        push("len0q", 3'd6, 0, 1, 0, 0, 0, 1);
        step(4);
        in_len = 4'd0;
        step(4);
        in_valid = 1'b0;
        step(2);

        // reset mid-word
        in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd8;
        push("rst0", 3'd6, 0, 1, 0, 0, 0, 1);
        push("rst1", 3'd6, 1, 0, 0, 1, 0, 0);
        push("rst2", 3'd7, 0, 1, 0, 1, 0, 0);
        push("rst3", 3'd0, 1, 0, 0, 1, 0, 0);
        push("rst4", 3'd0, 0, 0, 0, 0, 0, 1);
        push("rst5", 3'd4, 0, 0, 1, 0, 0, 1);
        push("rst6", 3'd5, 0, 0, 0, 0, 0, 1);
        step(1);
        in_valid = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);

`ifdef PROJ3_DRV_CHECK_EN
        // one-cycle m_in disagreement sets a sticky flag until reset
        inject = 1'b1;
        push("mm0", 3'd7, 0, 1, 0, 0, 0, 1, 1'b0);
        push("mm1", 3'd0, 0, 0, 0, 0, 0, 1, 1'b1);
        push("mm2", 3'd4, 0, 0, 1, 0, 0, 1, 1'b1);
        push("mm3", 3'd0, 0, 0, 0, 0, 0, 1, 1'b0);
        step(1);
        inject = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proj3_seq_driver.md
# proj3_seq_driver

Bit-serial stimulus transmitter for the `Proj_3` 8-state sequence FSM. It drives the peer's `a` input.
- Accepts branch-decision words over a valid/ready handshake.
- Keeps a cycle-accurate shadow copy of the peer's state, so a decision bit is spent only where the peer actually branches.
- Publishes the expected `m`/`n` outputs for downstream checking.
- Sits between the test/control logic and the `Proj_3` instance, on the same clock.

## Interface
Parameters:
- `WORD_W`, 8, decision bits per word; LSB sent first.

Ports:
- `clk`  in  1  rising-edge clock, shared with the peer FSM.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  decision word offered.
- `in_ready`  out  1  high while IDLE.
- `in_data`  in  `WORD_W`  decision bits, LSB first.
- `in_len`  in  `LEN_W`  number of decision bits to send; `LEN_W` = `$clog2(WORD_W+1)`.
- `a`  out  1  serial output; drives the peer's `a`.
- `busy`  out  1  high in SEND.
- `word_done`  out  1  one-cycle pulse after the last decision bit is sent.
- `shadow_state`  out  3  predicted peer state.
- `m_exp`, `n_exp`  out  1  predicted peer `m`/`n`.
- `m_in`, `n_in`  in  1  actual peer outputs; present only with `PROJ3_DRV_CHECK_EN`.
- `mismatch`  out  1  sticky error flag; present only with `PROJ3_DRV_CHECK_EN`.

## Operation
Control FSM has two states: IDLE and SEND.

IDLE:
- `in_ready`=1 and `a`=0.
- On `in_valid` with `in_len`≥1: load the shift register with `in_data` and set `count`=min(`in_len`, `WORD_W`), then go to SEND.
- `in_len`=0: the word is accepted, `word_done` pulses the next cycle, and the block stays in IDLE.

Shadow FSM advances every cycle, in every control state, using the `a` value it drives:
- 0: `a` → 1, else → 4.
- 1: `a` → 2, else → 3.
- 2: `a` → 3, else → 2.
- 3 → 4.
- 4 → 5.
- 5: `a` → 6, else → 7.
- 6: `a` → 7, else → 6.
- 7 → 0.

Branching states are {0,1,2,5,6}. In SEND:
- In a branching state: `a`=`shreg[0]`. At the clock edge the register shifts right and `count` decrements.
- In a non-branching state: `a`=0 and `count` is held.
- When `count` goes 1→0: return to IDLE and pulse `word_done` in the following cycle.

Expected outputs:
- `m_exp` = (s==7) | (s==2 & ~a) | (s==6 & ~a).
- `n_exp` = (s==3) | (s==4).

Peer alignment:
- The peer has no reset, so aligning it to state 0 at reset is the system's job.
- The driver resets its shadow to 0.

## Timing
- Reset (`rst_n`=0 at an edge) sets:
  - control → IDLE;
  - `shadow_state`=0 and `count`=0;
  - `a`=0, `busy`=0, `word_done`=0, `mismatch`=0;
  - `in_ready`=1 from the next cycle.
- Reset during SEND drops the in-flight word; no `word_done` is issued.
- `a` is derived from registers only; there is no combinational path from `in_*` to `a`.
- The first decision bit can appear one cycle after acceptance, at the earliest.
- `in_ready` is 0 for the whole of SEND, so there is at least one IDLE cycle between words.
- `word_done` is asserted in that first IDLE cycle.
- Throughput is `in_len` bits in (`in_len` + non-branching cycles) cycles.
- States 2 and 6 with `a`=0 self-loop and spend a bit each cycle.

## Configuration
`PROJ3_DRV_CHECK_EN`:
- Defined: adds the `m_in`/`n_in` ports and the `mismatch` port. `mismatch` sets one cycle after any cycle where {`m_in`,`n_in`} ≠ {`m_exp`,`n_exp`} and clears only on reset.
- Undefined: those ports and the comparator logic are absent.

## Structure
- Package `proj3_pkg` holds:
  - the 3-bit `proj3_state_t`;
  - the `BRANCH_MASK` constant (8'b0110_0111);
  - the next-state and expected-output functions, shared with the verification model.
- Sub-module `proj3_shadow`: the shadow FSM and expected-output generation, with inputs `a` and `clk`/`rst_n`.

## Test plan
- **Idle free-run:** reset, no `in_valid` → `shadow_state` 0,4,5,7,0,… with `a`=0; `n_exp`=1 at 4; `m_exp`=1 at 7.
- **Two-bit word:** `in_data`=8'h03, `in_len`=2 accepted at shadow 0 → `a` sequence 0 (s4), 1 (s5), 1 (s6); shadow reaches 7; `word_done` pulses exactly once with `in_ready` high.
- **Self-loop:** `in_data`=8'h13, `in_len`=5 accepted at shadow 7 (SEND starts at 0) → `a` 1,1,0,0,1; shadow 0,1,2,2,2,3; `m_exp`=1 in both s2 cycles where `a`=0.
- **Back-to-back:** `in_valid` held with two len-1 words → second accept occurs only after `word_done`; one IDLE gap; `in_len`=0 word → immediate `word_done`, no `a`=1 emitted.
- **Reset mid-word:** `rst_n`=0 for one edge during SEND → next cycle `shadow_state`=0, `busy`=0, no `word_done`.
- **`PROJ3_DRV_CHECK_EN` defined:** invert `m_in` for one cycle → `mismatch`=1 on the next edge and stays 1 until reset.
